// File: rtl/dice_oc_pkg.sv
// Shared types and field-split helpers for the DICE operand collector.
// Optional build macro: DICE_OC_PERF_EN (bank-conflict counter).
package dice_oc_pkg;

    typedef enum logic [1:0] {
        OC_IDLE    = 2'd0,
        OC_COLLECT = 2'd1,
        OC_DONE    = 2'd2
    } oc_state_e;

    // Register number = {row, bank}: bank field sits at the LSBs.
    localparam int OC_BANK_LSB = 0;
    localparam int OC_PERF_W   = 32;

    function automatic int oc_row_lsb(input int num_bank);
        return $clog2(num_bank);
    endfunction

endpackage

// File: rtl/dice_oc_bank_arb.sv
// Lowest-index-first grant among the pending sources mapped to one bank.
module dice_oc_bank_arb #(
    parameter int NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic [NUM_SRC-1:0] o_grant,
    output logic               o_any
);

    assign o_grant = i_req & (~i_req + NUM_SRC'(1));
    assign o_any   = |i_req;

endmodule

// File: rtl/dice_operand_collector.sv
// Gathers up to NUM_SRC operands from banked register files, one read per bank per cycle.
// Optional build macro: DICE_OC_PERF_EN adds perf_conflict_cnt.
module dice_operand_collector
    import dice_oc_pkg::*;
#(
    parameter int NUM_BANK = 4,
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 512,
    parameter int NUM_SRC  = 3,
    parameter int TAG_W    = 8,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int BANK_W     = oc_row_lsb(NUM_BANK),
    localparam int REG_W      = ADDR_WIDTH + BANK_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [TAG_W-1:0]               req_tag,
    input  logic [NUM_SRC-1:0]             req_src_en,
    input  logic [NUM_SRC*REG_W-1:0]       req_src_reg,
    output logic [NUM_BANK-1:0]            rf_rd_en,
    output logic [NUM_BANK*ADDR_WIDTH-1:0] rf_rd_addr,
    input  logic [NUM_BANK*WIDTH-1:0]      rf_rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [TAG_W-1:0]               out_tag,
    output logic [NUM_SRC-1:0]             out_src_en,
    output logic [NUM_SRC*WIDTH-1:0]       out_data
`ifdef DICE_OC_PERF_EN
    ,
    output logic [OC_PERF_W-1:0]           perf_conflict_cnt
`endif
);

    oc_state_e                r_state;
    oc_state_e                w_state_next;
    logic [TAG_W-1:0]         r_tag;
    logic [NUM_SRC-1:0]       r_src_en;
    logic [NUM_SRC-1:0]       r_pending;
    logic [NUM_SRC-1:0]       r_capture;
    logic [NUM_SRC*REG_W-1:0] r_regs;
    logic [NUM_SRC*WIDTH-1:0] r_data;

    logic                     w_accept;
    logic                     w_collect;
    logic [NUM_SRC-1:0]       w_issue;
    logic [NUM_BANK-1:0][NUM_SRC-1:0] w_grant;
    logic [BANK_W-1:0]        w_src_bank [NUM_SRC];
    logic [ADDR_WIDTH-1:0]    w_src_row  [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign w_src_bank[gi] = r_regs[gi*REG_W + OC_BANK_LSB +: BANK_W];
        assign w_src_row[gi]  = r_regs[gi*REG_W + BANK_W +: ADDR_WIDTH];
    end

    for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
        logic [NUM_SRC-1:0]    w_req;
        logic [NUM_SRC-1:0]    w_gnt;
        logic                  w_any;
        logic [ADDR_WIDTH-1:0] w_addr;

        always_comb begin
            w_req = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                w_req[s] = w_collect & r_pending[s] & (w_src_bank[s] == BANK_W'(gi));
            end
        end

        dice_oc_bank_arb #(.NUM_SRC(NUM_SRC)) u_arb (
            .i_req   (w_req),
            .o_grant (w_gnt),
            .o_any   (w_any)
        );

        // Grant is one-hot, so an AND-OR mux keeps the address 0 when idle.
        always_comb begin
            w_addr = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (w_gnt[s]) begin
                    w_addr = w_addr | w_src_row[s];
                end
            end
        end

        assign w_grant[gi]                              = w_gnt;
        assign rf_rd_en[gi]                             = w_any;
        assign rf_rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]  = w_addr;
    end

    always_comb begin
        w_issue = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            w_issue = w_issue | w_grant[b];
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        out_valid    = 1'b0;
        w_collect    = 1'b0;
        case (r_state)
            OC_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = OC_COLLECT;
            end
            OC_COLLECT: begin
                w_collect = 1'b1;
                // Empty pending here means the last round is being captured now.
                if (r_pending == '0) w_state_next = OC_DONE;
            end
            OC_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = OC_IDLE;
            end
            default: w_state_next = OC_IDLE;
        endcase
    end

    assign w_accept = req_valid & req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= OC_IDLE;
            r_tag     <= '0;
            r_src_en  <= '0;
            r_pending <= '0;
            r_capture <= '0;
            r_regs    <= '0;
            r_data    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_tag     <= req_tag;
                r_src_en  <= req_src_en;
                r_regs    <= req_src_reg;
                r_pending <= req_src_en;
                r_capture <= '0;
                r_data    <= '0;
            end else begin
                r_pending <= r_pending & ~w_issue;
                r_capture <= w_issue;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (r_capture[s]) begin
                        r_data[s*WIDTH +: WIDTH] <= rf_rd_data[int'(w_src_bank[s])*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    assign out_tag    = r_tag;
    assign out_src_en = r_src_en;
    assign out_data   = r_data;

`ifdef DICE_OC_PERF_EN
    logic [OC_PERF_W-1:0] r_perf_cnt;
    logic                 w_conflict;

    assign w_conflict = w_collect && ((r_pending & ~w_issue) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cnt <= '0;
        end else if (w_conflict && (r_perf_cnt != '1)) begin
            r_perf_cnt <= r_perf_cnt + OC_PERF_W'(1);
        end
    end

    assign perf_conflict_cnt = r_perf_cnt;
`else
    // Default build carries no conflict accounting.
`endif

endmodule

// File: tb/tb_dice_operand_collector.sv
// Directed bench for dice_operand_collector with a one-cycle-latency bank model.
// Honours DICE_OC_PERF_EN to also check perf_conflict_cnt.
module tb_dice_operand_collector;

    localparam int NUM_BANK = 4;
    localparam int WIDTH    = 32;
    localparam int NUM_SRC  = 3;
    localparam int TAG_W    = 8;
    localparam int AW       = 9;
    localparam int REG_W    = 11;

    logic                      clk;
    logic                      rst_n;
    logic                      req_valid;
    logic                      req_ready;
    logic [TAG_W-1:0]          req_tag;
    logic [NUM_SRC-1:0]        req_src_en;
    logic [NUM_SRC*REG_W-1:0]  req_src_reg;
    logic [NUM_BANK-1:0]       rf_rd_en;
    logic [NUM_BANK*AW-1:0]    rf_rd_addr;
    logic [NUM_BANK*WIDTH-1:0] rf_rd_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [TAG_W-1:0]          out_tag;
    logic [NUM_SRC-1:0]        out_src_en;
    logic [NUM_SRC*WIDTH-1:0]  out_data;
`ifdef DICE_OC_PERF_EN
    logic [31:0]               perf_conflict_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dice_operand_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_tag     (req_tag),
        .req_src_en  (req_src_en),
        .req_src_reg (req_src_reg),
        .rf_rd_en    (rf_rd_en),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_tag     (out_tag),
        .out_src_en  (out_src_en),
        .out_data    (out_data)
`ifdef DICE_OC_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: word = 0xA000_0000 | bank<<16 | row, returned one cycle after the read.
    always @(posedge clk) begin
        for (int b = 0; b < NUM_BANK; b++) begin
            if (rf_rd_en[b]) begin
                rf_rd_data[b*WIDTH +: WIDTH] <= 32'hA000_0000 | (32'(b) << 16)
                                                | 32'(rf_rd_addr[b*AW +: AW]);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("PASS %s: %0h", tag, obs);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] tag, input logic [2:0] en,
                        input int r0, input int r1, input int r2);
        req_valid   = 1'b1;
        req_tag     = tag;
        req_src_en  = en;
        req_src_reg = {11'(r2), 11'(r1), 11'(r0)};
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_tag     = '0;
        req_src_en  = '0;
        req_src_reg = '0;
        out_ready   = 1'b0;
        rf_rd_data  = '0;

        sample();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_rd_en", rf_rd_en, 4'b0000);
        check("rst_out_data", out_data, 96'h0);
        next_cycle();
        rst_n = 1'b1;

        // One round: regs 1,2,3 on banks 1..3
        next_cycle();
        send(8'h11, 3'b111, 1, 2, 3);
        sample();
        check("t1_req_ready", req_ready, 1'b1);
        next_cycle();
        req_valid = 1'b0;
        sample();
        check("t1_rd_en_r1", rf_rd_en, 4'b1110);
        check("t1_rd_addr_r1", rf_rd_addr, 36'h0);
        check("t1_valid_t1", out_valid, 1'b0);
        next_cycle();
        sample();
        check("t1_rd_en_t2", rf_rd_en, 4'b0000);
        check("t1_valid_t2", out_valid, 1'b0);
        next_cycle();
        out_ready = 1'b1;
        sample();
        check("t1_valid_t3", out_valid, 1'b1);
        check("t1_tag", out_tag, 8'h11);
        check("t1_data", out_data, {32'hA003_0000, 32'hA002_0000, 32'hA001_0000});
        check("t1_req_ready_done", req_ready, 1'b0);
        next_cycle();
        out_ready = 1'b0;
        sample();
        check("t1_idle_ready", req_ready, 1'b1);
        check("t1_idle_valid", out_valid, 1'b0);
`ifdef DICE_OC_PERF_EN
        check("t1_perf", perf_conflict_cnt, 32'd0);
`endif

        // Three rounds on bank 0, then a stalled DONE
        next_cycle();
        send(8'h22, 3'b111, 4, 8, 12);
        sample();
        next_cycle();
        req_valid = 1'b0;
        sample();
        check("t2_rd_en_r1", rf_rd_en, 4'b0001);
        check("t2_rd_addr_r1", rf_rd_addr, 36'd1);
        next_cycle();
        sample();
        check("t2_rd_en_r2", rf_rd_en, 4'b0001);
        check("t2_rd_addr_r2", rf_rd_addr, 36'd2);
        next_cycle();
        sample();
        check("t2_rd_en_r3", rf_rd_en, 4'b0001);
        check("t2_rd_addr_r3", rf_rd_addr, 36'd3);
        next_cycle();
        sample();
        check("t2_rd_en_t4", rf_rd_en, 4'b0000);
        check("t2_valid_t4", out_valid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            sample();
            check("t2_hold_valid", out_valid, 1'b1);
            check("t2_hold_data", out_data, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001});
            check("t2_hold_tag", out_tag, 8'h22);
            check("t2_hold_req_ready", req_ready, 1'b0);
            check("t2_hold_rd_en", rf_rd_en, 4'b0000);
        end
        next_cycle();
        out_ready = 1'b1;
        sample();
        check("t2_handshake_valid", out_valid, 1'b1);
        check("t2_handshake_req_ready", req_ready, 1'b0);
        next_cycle();
        out_ready = 1'b0;
        sample();
        check("t2_idle_ready", req_ready, 1'b1);
        check("t2_idle_valid", out_valid, 1'b0);
`ifdef DICE_OC_PERF_EN
        check("t2_perf", perf_conflict_cnt, 32'd2);
`endif

        // No sources enabled
        next_cycle();
        send(8'h33, 3'b000, 7, 9, 10);
        sample();
        next_cycle();
        req_valid = 1'b0;
        sample();
        check("t3_rd_en", rf_rd_en, 4'b0000);
        check("t3_valid_t1", out_valid, 1'b0);
        next_cycle();
        out_ready = 1'b1;
        sample();
        check("t3_valid_t2", out_valid, 1'b1);
        check("t3_data", out_data, 96'h0);
        check("t3_src_en", out_src_en, 3'b000);
        check("t3_tag", out_tag, 8'h33);
        next_cycle();
        out_ready = 1'b0;
        sample();
        check("t3_idle_ready", req_ready, 1'b1);

        // Duplicate register: 5,5,6
        next_cycle();
        send(8'h44, 3'b111, 5, 5, 6);
        sample();
        next_cycle();
        req_valid = 1'b0;
        sample();
        check("t4_rd_en_r1", rf_rd_en, 4'b0110);
        check("t4_rd_addr_r1", rf_rd_addr, 36'h0_0004_0200);
        next_cycle();
        sample();
        check("t4_rd_en_r2", rf_rd_en, 4'b0010);
        check("t4_rd_addr_r2", rf_rd_addr, 36'h0_0000_0200);
        next_cycle();
        sample();
        check("t4_rd_en_t3", rf_rd_en, 4'b0000);
        check("t4_valid_t3", out_valid, 1'b0);
        next_cycle();
        out_ready = 1'b1;
        sample();
        check("t4_valid_t4", out_valid, 1'b1);
        check("t4_data", out_data, {32'hA002_0001, 32'hA001_0001, 32'hA001_0001});
        check("t4_slot_dup", out_data[31:0], out_data[63:32]);
        next_cycle();
        out_ready = 1'b0;
        sample();
        check("t4_idle_ready", req_ready, 1'b1);
`ifdef DICE_OC_PERF_EN
        check("t4_perf", perf_conflict_cnt, 32'd3);
`endif

        // Reset mid-collect, then a fresh request
        next_cycle();
        send(8'h55, 3'b111, 4, 8, 12);
        sample();
        next_cycle();
        req_valid = 1'b0;
        sample();
        check("t5_rd_en_r1", rf_rd_en, 4'b0001);
        next_cycle();
        rst_n = 1'b0;
        sample();
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_rd_en", rf_rd_en, 4'b0000);
        check("t5_rst_req_ready", req_ready, 1'b1);
        check("t5_rst_data", out_data, 96'h0);
`ifdef DICE_OC_PERF_EN
        check("t5_rst_perf", perf_conflict_cnt, 32'd0);
`endif
        next_cycle();
        rst_n = 1'b1;
        sample();
        check("t5_post_rd_en", rf_rd_en, 4'b0000);
        check("t5_post_ready", req_ready, 1'b1);
        next_cycle();
        send(8'h66, 3'b101, 1, 2, 3);
        sample();
        next_cycle();
        req_valid = 1'b0;
        sample();
        check("t5_rd_en_new", rf_rd_en, 4'b1010);
        check("t5_rd_addr_new", rf_rd_addr, 36'h0);
        next_cycle();
        sample();
        check("t5_valid_t2", out_valid, 1'b0);
        next_cycle();
        out_ready = 1'b1;
        sample();
        check("t5_valid_t3", out_valid, 1'b1);
        check("t5_data", out_data, {32'hA003_0000, 32'h0, 32'hA001_0000});
        check("t5_src_en", out_src_en, 3'b101);
        check("t5_tag", out_tag, 8'h66);
        next_cycle();
        out_ready = 1'b0;
        sample();
        check("t5_idle_ready", req_ready, 1'b1);
        check("t5_idle_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
